// File: rtl/skinny_masked_pkg.sv
// Shared definitions for the masked SKINNY SubCells stage: FSM encoding,
// sbox register depth and randomness/share sizing helpers.
package skinny_masked_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } fsm_state_t;

    // Register depth of skinny_sbox8_domd_non_pipelined (one DOM AND layer per stage).
    localparam int SB_LAT = 4;
    localparam int N_SBOX = 16;

    function automatic int n_shares(input int dd);
        return dd + 1;
    endfunction

    // Fresh bits for one DOM AND gate.
    function automatic int rnd_per_and(input int dd);
        return dd * (dd + 1) / 2;
    endfunction

    // Fresh bits for one 8-bit sbox: 4 layers x 2 AND gates.
    function automatic int rnd_per_sbox(input int dd);
        return 8 * dd * (dd + 1) / 2;
    endfunction

endpackage

// File: rtl/skinny_sbox8_domd_non_pipelined.sv
// d-th order DOM-masked SKINNY S8. Four MIX layers, each with two masked
// NOR gates (~a & ~b, the NOT folded into share 0) and a register stage.
// The input must be held for SB_LAT cycles before so is valid.
module skinny_sbox8_domd_non_pipelined
    import skinny_masked_pkg::*;
#(
    parameter int d = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*(d+1)-1:0]        si,
    input  logic [rnd_per_sbox(d)-1:0] rnd,
    output logic [8*(d+1)-1:0]        so
);
    localparam int NS = n_shares(d);
    localparam int RA = rnd_per_and(d);

    // DOM-independent AND: cross terms are refreshed with one bit per share pair.
    function automatic logic [NS-1:0] dom_and(input logic [NS-1:0] a,
                                              input logic [NS-1:0] b,
                                              input logic [RA-1:0] r);
        logic [NS-1:0] c;
        c = a & b;
        for (int i = 0; i < NS; i++) begin
            for (int j = i + 1; j < NS; j++) begin
                c[i] = c[i] ^ (a[i] & b[j]) ^ r[i*NS - i*(i+1)/2 + (j-i-1)];
                c[j] = c[j] ^ (a[j] & b[i]) ^ r[i*NS - i*(i+1)/2 + (j-i-1)];
            end
        end
        return c;
    endfunction

    // Bit permutation between MIX layers, applied share-wise.
    function automatic logic [8*NS-1:0] perm_sh(input logic [8*NS-1:0] x);
        logic [8*NS-1:0] p;
        for (int i = 0; i < NS; i++) begin
            p[8*i +: 8] = {x[8*i+2], x[8*i+1], x[8*i+7], x[8*i+6],
                           x[8*i+4], x[8*i+0], x[8*i+3], x[8*i+5]};
        end
        return p;
    endfunction

    // Final output swap of bits 1 and 2, applied share-wise.
    function automatic logic [8*NS-1:0] swap_sh(input logic [8*NS-1:0] x);
        logic [8*NS-1:0] s;
        for (int i = 0; i < NS; i++) begin
            s[8*i +: 8] = {x[8*i+7 -: 5], x[8*i+1], x[8*i+2], x[8*i+0]};
        end
        return s;
    endfunction

    for (genvar l = 0; l < SB_LAT; l++) begin : g_layer
        logic [8*NS-1:0] x;
        logic [8*NS-1:0] y;
        logic [8*NS-1:0] q;
        logic [2*RA-1:0] r;
        logic [NS-1:0]   a_lo, b_lo, a_hi, b_hi, n_lo, n_hi;

        assign r = rnd[l*2*RA +: 2*RA];

        if (l == 0) begin : g_first
            assign x = si;
        end else begin : g_next
            assign x = perm_sh(g_layer[l-1].q);
        end

        // MIX layer: bit0 ^= NOR(bit2,bit3), bit4 ^= NOR(bit6,bit7)
        always_comb begin
            for (int i = 0; i < NS; i++) begin
                a_lo[i] = x[8*i+2] ^ (i == 0);
                b_lo[i] = x[8*i+3] ^ (i == 0);
                a_hi[i] = x[8*i+6] ^ (i == 0);
                b_hi[i] = x[8*i+7] ^ (i == 0);
            end
            n_lo = dom_and(a_lo, b_lo, r[RA-1:0]);
            n_hi = dom_and(a_hi, b_hi, r[2*RA-1:RA]);
            y = x;
            for (int i = 0; i < NS; i++) begin
                y[8*i]   = x[8*i]   ^ n_lo[i];
                y[8*i+4] = x[8*i+4] ^ n_hi[i];
            end
        end

        // Layer register stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) q <= '0;
            else     q <= y;
        end
    end

    assign so = swap_sh(g_layer[SB_LAT-1].q);

endmodule

// File: rtl/skinny_share_byte_mux.sv
// Regroups the share-major round state ({share j, byte k}) into the
// sbox-major layout (sbox k gets byte k of every share) and back again.
// Pure wiring: shares are moved, never combined.
module skinny_share_byte_mux
    import skinny_masked_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [128*(d+1)-1:0] state,
    output logic [128*(d+1)-1:0] sb_in,
    input  logic [128*(d+1)-1:0] sb_out,
    output logic [128*(d+1)-1:0] result
);
    localparam int NS = n_shares(d);

    for (genvar k = 0; k < N_SBOX; k++) begin : g_byte
        for (genvar j = 0; j < NS; j++) begin : g_share
            assign sb_in[k*8*NS + 8*j +: 8]  = state[128*j + 8*k +: 8];
            assign result[128*j + 8*k +: 8] = sb_out[k*8*NS + 8*j +: 8];
        end
    end

endmodule

// File: rtl/skinny_subcells_domd_ctrl.sv
// Masked SubCells stage for SKINNY-128-384+. Holds the share state stable
// while 16 DOM sboxes settle, counting only cycles with fresh randomness;
// a starved cycle restarts the count so held inputs never meet reused rnd.
// Optional: SKINNY_SUBCELLS_ZEROIZE_EN clears state_q/out_state on HOLD->IDLE.
module skinny_subcells_domd_ctrl
    import skinny_masked_pkg::*;
#(
    parameter int d      = 2,
    parameter int SB_LAT = skinny_masked_pkg::SB_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [128*(d+1)-1:0]      in_state,
    input  logic [64*d*(d+1)-1:0]     rnd,
    input  logic                      rnd_valid,
    output logic                      rnd_req,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [128*(d+1)-1:0]      out_state,
    output logic                      restart
);
    localparam int NS    = n_shares(d);
    localparam int RPS   = rnd_per_sbox(d);
    localparam int CNT_W = (SB_LAT > 1) ? $clog2(SB_LAT) : 1;

    fsm_state_t           st;
    logic [CNT_W-1:0]     cnt;
    logic [128*NS-1:0]    state_q;
    logic [128*NS-1:0]    sb_in;
    logic [128*NS-1:0]    sb_out;
    logic [128*NS-1:0]    sb_result;

    skinny_share_byte_mux #(.d(d)) u_mux (
        .state  (state_q),
        .sb_in  (sb_in),
        .sb_out (sb_out),
        .result (sb_result)
    );

    for (genvar k = 0; k < N_SBOX; k++) begin : g_sbox
        skinny_sbox8_domd_non_pipelined #(.d(d)) u_sbox (
            .clk (clk),
            .rst (rst),
            .si  (sb_in[k*8*NS +: 8*NS]),
            .rnd (rnd[k*RPS +: RPS]),
            .so  (sb_out[k*8*NS +: 8*NS])
        );
    end

    // Control FSM, latency counter and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= ST_IDLE;
            cnt       <= '0;
            state_q   <= '0;
            out_state <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rnd_req   <= 1'b0;
            restart   <= 1'b0;
        end else begin
            restart <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q  <= in_state;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        rnd_req  <= 1'b1;
                        st       <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (rnd_valid) begin
                        if (cnt == CNT_W'(SB_LAT - 1)) begin
                            cnt     <= '0;
                            rnd_req <= 1'b0;
                            st      <= ST_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        // Partial sbox progress is discarded; count from scratch.
                        cnt     <= '0;
                        restart <= 1'b1;
                    end
                end
                ST_DONE: begin
                    out_state <= sb_result;
                    out_valid <= 1'b1;
                    st        <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        st        <= ST_IDLE;
`ifdef SKINNY_SUBCELLS_ZEROIZE_EN
                        state_q   <= '0;
                        out_state <= '0;
`else
                        state_q   <= state_q;
                        out_state <= out_state;
`endif
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skinny_subcells_domd_ctrl.sv
// Self-checking bench for skinny_subcells_domd_ctrl (d=2). The reference
// model unmasks the shares, applies SKINNY S8 bytewise and tracks the
// expected handshake timing from the accept edge.
module tb_skinny_subcells_domd_ctrl;
    localparam int D  = 2;
    localparam int NS = D + 1;
    localparam int SW = 128 * NS;
    localparam int RW = 64 * D * NS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_state;
    logic [RW-1:0] rnd;
    logic          rnd_valid;
    logic          rnd_req;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_state;
    logic          restart;

    int checks = 0;
    int errors = 0;

    skinny_subcells_domd_ctrl #(.d(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .rnd       (rnd),
        .rnd_valid (rnd_valid),
        .rnd_req   (rnd_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .restart   (restart)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < RW / 32; i++) rnd[32*i +: 32] = $urandom();
    end

    // SKINNY 8-bit sbox: four MIX rounds with permutations, final bit swap.
    function automatic logic [7:0] s8(input logic [7:0] v);
        logic [7:0] x;
        x = v;
        for (int r = 0; r < 4; r++) begin
            x = ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
            if (r < 3)
                x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
                    ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
        end
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] u);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = s8(u[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] unmask(input logic [SW-1:0] s);
        logic [127:0] u;
        u = '0;
        for (int j = 0; j < NS; j++) u = u ^ s[128*j +: 128];
        return u;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [SW-1:0] make_shares(input logic [127:0] u);
        logic [SW-1:0] s;
        logic [127:0]  acc;
        acc = u;
        for (int j = 1; j < NS; j++) begin
            s[128*j +: 128] = rand128();
            acc = acc ^ s[128*j +: 128];
        end
        s[127:0] = acc;
        return s;
    endfunction

    // Push one state through, optionally starving rnd in CALC cycle drop_at,
    // stalling out_ready for hold_cycles and waving in_valid while busy.
    task automatic run_state(input logic [127:0] unm, input int drop_at, input int hold_cycles,
                             input bit noise, output logic [SW-1:0] got, output logic [SW-1:0] sh);
        int c, lat, exp_lat, nreq, nrst;
        bit busy_ok, hold_ok, seen;
        sh = make_shares(unm);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_state = sh; in_valid = 1'b1; rnd_valid = 1'b1;
        @(posedge clk);
        c = 0; nreq = 0; nrst = 0; busy_ok = 1'b1; seen = 1'b0;
        while (c < 40 && !seen) begin
            @(negedge clk);
            c++;
            if (noise) begin
                in_valid = 1'b1;
                in_state = {rand128(), rand128(), rand128()};
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (rnd_req === 1'b1) nreq++;
                if (restart === 1'b1) nrst++;
                if (in_ready !== 1'b0) busy_ok = 1'b0;
                rnd_valid = (c != drop_at);
            end
        end
        in_valid = 1'b0; rnd_valid = 1'b1;
        lat = c - 1;
        exp_lat = 5 + ((drop_at > 0) ? drop_at : 0);
        got = out_state;

        checks++;
        if (!seen || lat != exp_lat) begin
            errors++;
            $display("FAIL latency: seen=%0d latency=%0d required %0d", seen, lat, exp_lat);
        end
        checks++;
        if (nreq != exp_lat - 1) begin
            errors++;
            $display("FAIL rnd_req_cycles: got %0d required %0d", nreq, exp_lat - 1);
        end
        checks++;
        if (nrst != ((drop_at > 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL restart_pulses: got %0d required %0d", nrst, (drop_at > 0) ? 1 : 0);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL busy_in_ready: in_ready was 1 while busy, required 0");
        end
        checks++;
        if (unmask(got) !== sub_bytes(unm)) begin
            errors++;
            $display("FAIL sbox_result: got %h required %h", unmask(got), sub_bytes(unm));
        end

        hold_ok = 1'b1;
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== got) hold_ok = 1'b0;
        end
        if (hold_cycles > 0) begin
            checks++;
            if (!hold_ok) begin
                errors++;
                $display("FAIL hold_stable: out_valid=%b in_ready=%b required stable 1/0", out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_idle: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || rnd_req !== 1'b0 || restart !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b rnd_req=%b restart=%b required 1000",
                     in_ready, out_valid, rnd_req, restart);
        end
        checks++;
        if (out_state !== '0) begin
            errors++;
            $display("FAIL reset_out_state: got %h required 0", out_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_state();
        logic [SW-1:0] got, sh;
        run_state(128'h0, 0, 0, 1'b0, got, sh);
        checks++;
        if (unmask(got) !== {16{8'h65}}) begin
            errors++;
            $display("FAIL zero_state: got %h required all 65", unmask(got));
        end
    endtask

    task automatic test_s8_table();
        logic [SW-1:0] got, sh;
        logic [127:0]  u;
        for (int s = 0; s < 16; s++) begin
            for (int k = 0; k < 16; k++) u[8*k +: 8] = 8'(16 * s + k);
            run_state(u, 0, 0, 1'b0, got, sh);
        end
    endtask

    task automatic test_restart();
        logic [SW-1:0] got, sh;
        run_state(rand128(), 3, 0, 1'b0, got, sh);
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] got, sh;
        run_state(rand128(), 0, 10, 1'b0, got, sh);
    endtask

    task automatic test_reset_mid_calc();
        logic [SW-1:0] got, sh;
        @(negedge clk);
        in_state = make_shares(rand128()); in_valid = 1'b1; rnd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || rnd_req !== 1'b0 || restart !== 1'b0 || out_state !== '0) begin
            errors++;
            $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b rnd_req=%b restart=%b required 1000 and zero state",
                     in_ready, out_valid, rnd_req, restart);
        end
        @(negedge clk);
        rst = 1'b0;
        run_state(rand128(), 0, 0, 1'b0, got, sh);
    endtask

    task automatic test_zeroize();
        logic [SW-1:0] got, sh, exp_out, exp_q;
        run_state(rand128(), 0, 2, 1'b0, got, sh);
`ifdef SKINNY_SUBCELLS_ZEROIZE_EN
        exp_out = '0;
        exp_q   = '0;
`else
        exp_out = got;
        exp_q   = sh;
`endif
        checks++;
        if (out_state !== exp_out) begin
            errors++;
            $display("FAIL zeroize_out_state: got %h required %h", out_state, exp_out);
        end
        checks++;
        if (dut.state_q !== exp_q) begin
            errors++;
            $display("FAIL zeroize_state_q: got %h required %h", dut.state_q, exp_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] got, sh;
        for (int n = 0; n < 4; n++) run_state(rand128(), 0, n, 1'b1, got, sh);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_state = '0; rnd_valid = 1'b1; out_ready = 1'b0;
        test_reset();
        test_zero_state();
        test_s8_table();
        test_restart();
        test_backpressure();
        test_reset_mid_calc();
        test_zeroize();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
